data_postprocessing: RTL and testbench
======================================

// Module: data_postprocessing
// PURPOSE
// - Output-side counterpart of the conv input delay stage: takes signed conv accumulator results,
//   requantizes them to DATA_BW and streams them out on an AXI-Stream master with backpressure.
// - Sits between the MAC/accumulator array and the AXI output DMA.
// - Frames the stream with tlast every FRAME_LEN beats.
// PARAMETERS
// - ACC_BW      20  signed accumulator input width
// - DATA_BW     8   signed output sample width
// - SHIFT       4   requant right-shift; 0 = pass-through, no rounding
// - FIFO_DEPTH  4   output FIFO entries, power of 2, >= 2
// - FRAME_LEN   16  beats per frame; m_tlast is asserted on the last one, >= 1
// PORTS
// - clk            in   1        single clock, all logic on rising edge
// - rst            in   1        reset: synchronous, active-high
// - i_acc_valid    in   1        accumulator word valid
// - i_acc          in   ACC_BW   signed accumulator word
// - o_acc_ready    out  1        block can accept i_acc this cycle
// - m_axis_tdata   out  DATA_BW  signed requantized sample
// - m_axis_tvalid  out  1        output valid
// - m_axis_tready  in   1        downstream ready
// - m_axis_tlast   out  1        last beat of frame
// BEHAVIOUR
// - Reset: one clock; reset is synchronous and active-high.
//   - Outputs: o_acc_ready=0, tvalid=0, tdata=0, tlast=0.
//   - Internal: FIFO empty, pipe valids cleared, beat counter=0, credits=FIFO_DEPTH.
//   - o_acc_ready rises the first cycle after rst deasserts.
//   - Reset mid-operation drops all in-flight and buffered data; no partial frame is resumed.
// - Input accept: i_acc_valid & o_acc_ready at edge E0.
// - Credits:
//   - o_acc_ready = (credits != 0).
//   - credits -1 on accept, +1 on output handshake (tvalid & tready).
//   - Simultaneous accept and output handshake leave credits unchanged.
//   - Credits make FIFO overflow impossible; o_acc_ready is registered, not combinational on tready.
// - Pipeline:
//   - S1 after E0: rounded = i_acc + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed at ACC_BW+1 bits
//     (no overflow); then arithmetic >>> SHIFT.
//   - S2 after E1: saturate to [-2^(DATA_BW-1), 2^(DATA_BW-1)-1]; optional ReLU (see CONFIGURATION).
//   - FIFO write at E2.
// - Latency: tvalid high after E2 if the FIFO was empty (3 edges); the pipe never stalls.
// - Output:
//   - tdata/tvalid/tlast are driven from the FIFO head.
//   - Once tvalid is high, tdata and tlast hold stable until handshake.
//   - Pop on tvalid & tready; the next entry is presented the following cycle, giving full
//     throughput of 1 beat/cycle with tready=1.
// - FIFO full and push in the same cycle as pop: legal, count unchanged. Empty: tvalid=0.
// - Beat counter:
//   - Increments on output handshake; wraps FRAME_LEN-1 -> 0.
//   - tlast = (count == FRAME_LEN-1) & tvalid.
//   - FRAME_LEN=1 means tlast is on every beat.
// CONFIGURATION
// - Macro POSTPROC_RELU_EN.
// - Defined: S2 clamps negative results to 0 after saturation; output range is [0, 2^(DATA_BW-1)-1].
// - Undefined: no ReLU; full signed saturated range. Latency is identical either way.
// TESTING
// - Single word, SHIFT=4, tready=1, after reset:
//   - i_acc=100 -> tdata=6 three edges after accept.
//   - i_acc=-100 -> tdata=-6.
// - Saturation, SHIFT=4:
//   - i_acc=5000 -> 127.
//   - i_acc=-5000 -> -128 (0 with POSTPROC_RELU_EN).
//   - i_acc=2039 -> 127.
//   - i_acc=2040 -> 127 (saturated).
// - Backpressure: tready=0, i_acc_valid held with ramp 16,32,48...
//   - Exactly 4 words accepted, then o_acc_ready=0.
//   - tdata holds 1 (first word) with tvalid high.
//   - Release tready -> outputs 1,2,3,4 in order, with no loss or duplication.
// - Streaming: 40 words, tready=1 always; throughput 1/cycle after fill.
//   - tlast on beats 16 and 32 only.
//   - Random-tready variant keeps order and matches the software golden model.
// - Simultaneous push/pop at full FIFO: credits unchanged, no overflow flag.
// - Reset mid-frame (beat 7, FIFO holding 3 entries):
//   - All outputs 0 next cycle; the next frame's tlast falls on its 16th beat.

Source files
------------

// File: rtl/data_postprocessing.sv
// Requantizes signed accumulator words (round, shift, saturate) and streams them out on
// an AXI-Stream master with credit-based input flow control. Optional ReLU: POSTPROC_RELU_EN.
module data_postprocessing #(
    parameter int ACC_BW     = 20,
    parameter int DATA_BW    = 8,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_acc_valid,
    input  logic signed [ACC_BW-1:0]  i_acc,
    output logic                      o_acc_ready,
    output logic signed [DATA_BW-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);

    localparam int RW = ACC_BW + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic signed [RW-1:0]      RND     = RW'((1 << SHIFT) >> 1);
    localparam logic signed [DATA_BW-1:0] OUT_MAX = {1'b0, {(DATA_BW-1){1'b1}}};
    localparam logic signed [DATA_BW-1:0] OUT_MIN = {1'b1, {(DATA_BW-1){1'b0}}};
    localparam logic signed [RW-1:0]      SAT_MAX = {{(RW-DATA_BW){1'b0}}, OUT_MAX};
    localparam logic signed [RW-1:0]      SAT_MIN = {{(RW-DATA_BW){1'b1}}, OUT_MIN};

    logic                      ready_q;
    logic [CW-1:0]             credits_q, credits_d;
    logic                      s1_valid_q, s2_valid_q;
    logic signed [RW-1:0]      s1_data_q, rounded_d, shifted_d;
    logic signed [DATA_BW-1:0] s2_data_q, sat_d;
    logic signed [DATA_BW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic                      accept, push, pop;

    assign accept = i_acc_valid & ready_q;
    assign push   = s2_valid_q;
    assign pop    = m_axis_tvalid & m_axis_tready;

    // One extra bit keeps the rounding add from overflowing before the shift.
    assign rounded_d = $signed({i_acc[ACC_BW-1], i_acc}) + RND;
    assign shifted_d = rounded_d >>> SHIFT;

    always_comb begin
        sat_d = s1_data_q[DATA_BW-1:0];
        if (s1_data_q > SAT_MAX) begin
            sat_d = OUT_MAX;
        end else if (s1_data_q < SAT_MIN) begin
            sat_d = OUT_MIN;
        end
`ifdef POSTPROC_RELU_EN
        if (sat_d[DATA_BW-1]) begin
            sat_d = '0;
        end
`else
`endif
    end

    // Credits count FIFO slots not yet claimed by words in the pipe or buffer.
    always_comb begin
        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (pop && !accept) begin
            credits_d = credits_q + CW'(1);
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        beat_d   = beat_q;
        if (pop) begin
            beat_d = (beat_q == BW'(FRAME_LEN - 1)) ? '0 : beat_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b0;
            credits_q  <= CW'(FIFO_DEPTH);
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_q     <= '0;
        end else begin
            ready_q    <= (credits_d != '0);
            credits_q  <= credits_d;
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            s1_data_q  <= shifted_d;
            s2_data_q  <= sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_q     <= beat_d;
        end
    end

    // Storage carries no reset; stale entries are never visible because tvalid tracks count.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PW'(gi))) begin
                mem_q[gi] <= s2_data_q;
            end
        end
    end

    assign o_acc_ready   = ready_q;
    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (beat_q == BW'(FRAME_LEN - 1));

endmodule

// File: tb/tb_data_postprocessing.sv
// Self-checking bench for data_postprocessing: vector table, hand sequences for
// backpressure/framing/reset, and a randomized run against a queue-based golden model.
module tb_data_postprocessing;

    localparam int ACC_BW     = 20;
    localparam int DATA_BW    = 8;
    localparam int SHIFT      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_LEN  = 16;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      i_acc_valid = 1'b0;
    logic signed [ACC_BW-1:0]  i_acc = '0;
    logic                      o_acc_ready;
    logic signed [DATA_BW-1:0] m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready = 1'b0;
    logic                      m_axis_tlast;

    always #5 clk = ~clk;

    data_postprocessing #(
        .ACC_BW(ACC_BW), .DATA_BW(DATA_BW), .SHIFT(SHIFT),
        .FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .i_acc_valid(i_acc_valid), .i_acc(i_acc), .o_acc_ready(o_acc_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden requantization: floor((a + half) / 2^SHIFT), clamp to output range.
    function automatic int requant(input int a);
        int num, d, q, lo, hi;
        d   = 1 << SHIFT;
        num = a + d / 2;
        q   = num / d;
        if (num < 0 && (num % d) != 0) q = q - 1;
        hi = (1 << (DATA_BW - 1)) - 1;
        lo = -(1 << (DATA_BW - 1));
`ifdef POSTPROC_RELU_EN
        lo = 0;
`endif
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    // Monitor: samples at the falling edge and predicts the next rising-edge behaviour.
    typedef struct { int val; int avail; } exp_t;
    exp_t mq[$];
    int   m_credits = FIFO_DEPTH;
    int   m_beat = 0;
    int   m_age = 0;
    int   m_cyc = 0;

    always @(negedge clk) begin
        m_cyc++;
        if (rst) begin
            mq.delete();
            m_credits = FIFO_DEPTH;
            m_beat    = 0;
            m_age     = 0;
        end else begin
            chk("mon_ready", int'(o_acc_ready), (m_age == 0) ? 0 : int'(m_credits != 0));
            chk("mon_tvalid", int'(m_axis_tvalid), int'(mq.size() > 0 && mq[0].avail <= m_cyc));
            if (m_axis_tvalid) begin
                if (mq.size() > 0) chk("mon_tdata", int'(m_axis_tdata), mq[0].val);
                chk("mon_tlast", int'(m_axis_tlast), int'(m_beat == FRAME_LEN - 1));
            end else begin
                chk("mon_tlast_idle", int'(m_axis_tlast), 0);
            end
            if (i_acc_valid && o_acc_ready) begin
                mq.push_back('{val: requant(int'(i_acc)), avail: m_cyc + 3});
                m_credits--;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (mq.size() > 0) void'(mq.pop_front());
                m_credits++;
                m_beat = (m_beat + 1) % FRAME_LEN;
            end
            m_age++;
        end
    end

    // Stimulus-side view: handshakes seen at each rising edge.
    logic hs_q = 1'b0;
    logic acc_q = 1'b0;
    int   hs_cnt = 0;
    int   hs_data = 0;
    logic hs_last = 1'b0;
    int   tl_beats[$];

    task automatic tick();
        hs_q    = m_axis_tvalid && m_axis_tready;
        acc_q   = i_acc_valid && o_acc_ready;
        hs_data = int'(m_axis_tdata);
        hs_last = m_axis_tlast;
        @(posedge clk);
        #1;
        if (hs_q) begin
            hs_cnt++;
            if (hs_last) tl_beats.push_back(hs_cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_acc_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic signed [ACC_BW-1:0] rand_acc();
        if ($urandom_range(0, 1) == 1)
            return ACC_BW'($urandom_range(0, 6000)) - ACC_BW'(3000);
        return ACC_BW'($urandom);
    endfunction

    // Streams nw random words with tready=1; returns cycles between first and last beat.
    task automatic run_stream(input int nw, output int span);
        int sent, cyc, first, last;
        sent = 0; cyc = 0; first = -1; last = -1;
        hs_cnt = 0;
        tl_beats.delete();
        m_axis_tready = 1'b1;
        i_acc = rand_acc();
        i_acc_valid = 1'b1;
        while (hs_cnt < nw && cyc < 400) begin
            tick();
            cyc++;
            if (acc_q) begin
                sent++;
                i_acc = rand_acc();
                if (sent == nw) i_acc_valid = 1'b0;
            end
            if (hs_q) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        i_acc_valid = 1'b0;
        span = last - first;
    endtask

    typedef struct { int acc; int exp; } vec_t;
    vec_t vecs[13];

    initial begin
        int n, span, n_acc, k, sent;
        int got[$];

        vecs[0]  = '{acc: 100,     exp: 6};
        vecs[1]  = '{acc: -100,    exp: -6};
        vecs[2]  = '{acc: 5000,    exp: 127};
        vecs[3]  = '{acc: -5000,   exp: -128};
        vecs[4]  = '{acc: 2039,    exp: 127};
        vecs[5]  = '{acc: 2040,    exp: 127};
        vecs[6]  = '{acc: 0,       exp: 0};
        vecs[7]  = '{acc: 7,       exp: 0};
        vecs[8]  = '{acc: 8,       exp: 1};
        vecs[9]  = '{acc: -8,      exp: 0};
        vecs[10] = '{acc: -9,      exp: -1};
        vecs[11] = '{acc: 524287,  exp: 127};
        vecs[12] = '{acc: -524288, exp: -128};

        // Reset state
        tick();
        do_reset();
        chk("rst_ready", int'(o_acc_ready), 0);
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_tdata", int'(m_axis_tdata), 0);
        chk("rst_tlast", int'(m_axis_tlast), 0);
        tick();
        chk("ready_after_rst", int'(o_acc_ready), 1);

        // Single-word vectors: latency and value
        m_axis_tready = 1'b1;
        foreach (vecs[i]) begin
            int e;
            e = vecs[i].exp;
`ifdef POSTPROC_RELU_EN
            if (e < 0) e = 0;
`endif
            i_acc = ACC_BW'(vecs[i].acc);
            i_acc_valid = 1'b1;
            tick();
            i_acc_valid = 1'b0;
            n = 1;
            while (!m_axis_tvalid && n < 10) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d_latency", i), n, 3);
            chk($sformatf("vec%0d_tdata", i), int'(m_axis_tdata), e);
            tick();
            tick();
        end

        // Backpressure: ramp 16,32,48... with tready low
        do_reset();
        tick();
        m_axis_tready = 1'b0;
        k = 1;
        n_acc = 0;
        i_acc = ACC_BW'(16);
        i_acc_valid = 1'b1;
        repeat (12) begin
            tick();
            if (acc_q) begin
                n_acc++;
                k++;
                i_acc = ACC_BW'(16 * k);
            end
        end
        chk("bp_accepted", n_acc, 4);
        chk("bp_ready_low", int'(o_acc_ready), 0);
        chk("bp_tvalid", int'(m_axis_tvalid), 1);
        chk("bp_tdata_hold", int'(m_axis_tdata), 1);
        i_acc_valid = 1'b0;
        m_axis_tready = 1'b1;
        got.delete();
        repeat (12) begin
            tick();
            if (hs_q) got.push_back(hs_data);
        end
        chk("bp_out_count", got.size(), 4);
        for (int j = 0; j < got.size() && j < 4; j++)
            chk($sformatf("bp_out%0d", j), got[j], j + 1);

        // Streaming 40 words: full throughput, tlast on beats 16 and 32
        do_reset();
        tick();
        run_stream(40, span);
        chk("stream_beats", hs_cnt, 40);
        chk("stream_span", span, 39);
        chk("stream_tlast_n", tl_beats.size(), 2);
        if (tl_beats.size() == 2) begin
            chk("stream_tlast_a", tl_beats[0], 16);
            chk("stream_tlast_b", tl_beats[1], 32);
        end

        // Random valid/tready: model checks order, data, tlast and credits
        for (int c = 0; c < 400; c++) begin
            i_acc = rand_acc();
            i_acc_valid = ($urandom_range(0, 3) != 0);
            m_axis_tready = ($urandom_range(0, 2) != 0);
            tick();
        end
        i_acc_valid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (12) tick();
        chk("rand_drained", int'(m_axis_tvalid), 0);
        chk("rand_model_empty", mq.size(), 0);

        // Reset mid-frame: 7 beats out, 3 buffered
        do_reset();
        tick();
        hs_cnt = 0;
        sent = 0;
        m_axis_tready = 1'b1;
        i_acc = ACC_BW'(16);
        i_acc_valid = 1'b1;
        n = 0;
        while (hs_cnt < 7 && n < 50) begin
            tick();
            n++;
            if (acc_q) begin
                sent++;
                i_acc = ACC_BW'(16 * (sent + 1));
            end
        end
        i_acc_valid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (4) tick();
        chk("mid_buffered", sent - hs_cnt, 3);
        chk("mid_tdata_head", int'(m_axis_tdata), 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_tvalid", int'(m_axis_tvalid), 0);
        chk("mid_rst_tdata", int'(m_axis_tdata), 0);
        chk("mid_rst_tlast", int'(m_axis_tlast), 0);
        chk("mid_rst_ready", int'(o_acc_ready), 0);
        tick();
        run_stream(16, span);
        chk("post_rst_beats", hs_cnt, 16);
        chk("post_rst_tlast_n", tl_beats.size(), 1);
        if (tl_beats.size() == 1) chk("post_rst_tlast_beat", tl_beats[0], 16);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
